// File: rtl/tlm_burst_streamer.sv
// Buffers one DEPTH-beat payload from a loader, then replays it over valid/ready, BURST_NUM times per run.
// Optional load checksum outputs are enabled by defining TLM_BURST_STREAMER_CSUM_EN.
module tlm_burst_streamer #(
  parameter int ITEM_WIDTH = 8,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 100,
  parameter int BURST_NUM  = 5
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 start_i,
  input  logic                                 load_valid_i,
  output logic                                 load_ready_o,
  input  logic [CHANNELS*ITEM_WIDTH-1:0]       load_data_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [CHANNELS*ITEM_WIDTH-1:0]       out_data_o,
  output logic                                 out_last_o,
  output logic [$clog2(BURST_NUM+1)-1:0]       burst_cnt_o,
  output logic                                 busy_o,
  output logic                                 done_o
`ifdef TLM_BURST_STREAMER_CSUM_EN
  ,
  output logic [ITEM_WIDTH-1:0]                csum_o,
  output logic                                 csum_valid_o
`endif
);

  localparam int DW = CHANNELS * ITEM_WIDTH;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(BURST_NUM + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_NUM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   burst_inc;
  logic            load_fire;
  logic            out_fire;
  logic            last_fire;
  logic            present;

  assign load_fire = load_valid_i && load_ready_o;
  assign out_fire  = out_valid_o && out_ready_i;
  assign last_fire = out_fire && out_last_o;
  assign burst_inc = burst_cnt_o + CW'(1);
  // A new beat is presented on stream entry (nothing valid yet) or right after a non-final transfer.
  assign present   = (state == STREAM) && (!out_valid_o || out_ready_i) && !last_fire;

  always_comb begin
    state_next   = state;
    load_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) state_next = LOAD;
      end
      LOAD: begin
        load_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (load_fire && (wr_ptr == LAST_PTR)) state_next = STREAM;
      end
      STREAM: begin
        busy_o = 1'b1;
        if (last_fire) state_next = (burst_inc == LAST_CNT) ? DONE : LOAD;
      end
      DONE: begin
        done_o = 1'b1;
        if (start_i) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      burst_cnt_o <= '0;
    end else begin
      state <= state_next;
      if (load_fire) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (present) begin
        out_valid_o <= 1'b1;
        out_data_o  <= mem[rd_ptr];
        out_last_o  <= (rd_ptr == LAST_PTR);
        rd_ptr      <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end else if (last_fire) begin
        out_valid_o <= 1'b0;
        out_last_o  <= 1'b0;
      end
      if (last_fire) begin
        burst_cnt_o <= burst_inc;
      end else if ((state == DONE) && start_i) begin
        burst_cnt_o <= '0;
      end
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (load_fire) mem[wr_ptr] <= load_data_i;
  end

`ifdef TLM_BURST_STREAMER_CSUM_EN
  logic [ITEM_WIDTH-1:0] csum_acc;
  logic [ITEM_WIDTH-1:0] beat_xor;
  logic                  enter_load;

  assign enter_load = (state_next == LOAD) && (state != LOAD);

  always_comb begin
    beat_xor = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      beat_xor = beat_xor ^ load_data_i[c*ITEM_WIDTH +: ITEM_WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      csum_acc     <= '0;
      csum_o       <= '0;
      csum_valid_o <= 1'b0;
    end else begin
      csum_valid_o <= 1'b0;
      if (enter_load) begin
        csum_acc <= '0;
      end else if (load_fire) begin
        csum_acc <= csum_acc ^ beat_xor;
        if (wr_ptr == LAST_PTR) begin
          csum_o       <= csum_acc ^ beat_xor;
          csum_valid_o <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: doc/tlm_burst_streamer.md
Name: tlm_burst_streamer

Overview:
- Synthesizable, parametrised successor to the testbench-side operand feeder.
- Captures one payload of DEPTH beats into an internal buffer. Each beat is CHANNELS operands of ITEM_WIDTH bits.
- Streams the payload to a DUT over a valid/ready interface, repeating load/stream for BURST_NUM bursts, then reports done.
- Sits between a DPI/host loader (load side) and the datapath under test (out side).

Parameters:
- ITEM_WIDTH, 8: bits per operand.
- CHANNELS, 2: operands per beat (A, B, ...); channel 0 occupies the LSBs.
- DEPTH, 100: beats per burst; must be >= 1.
- BURST_NUM, 5: bursts per run; must be >= 1.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  asynchronous active-high reset.
- start_i  in  1  one-cycle pulse; starts a run from IDLE or DONE.
- load_valid_i  in  1  load beat valid.
- load_ready_o  out  1  buffer accepting load beats.
- load_data_i  in  CHANNELS*ITEM_WIDTH  load beat.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  DUT accepts beat.
- out_data_o  out  CHANNELS*ITEM_WIDTH  output beat.
- out_last_o  out  1  high with final beat of a burst.
- burst_cnt_o  out  $clog2(BURST_NUM+1)  completed bursts in current run.
- busy_o  out  1  state is LOAD or STREAM.
- done_o  out  1  run complete.

Behaviour:
- Reset:
  - While reset_i is high: state=IDLE; load_ready_o, out_valid_o, out_last_o, busy_o, done_o = 0; out_data_o = 0; burst_cnt_o = 0; pointers = 0.
  - Buffer contents are not reset.
- States:
  - IDLE: start_i -> LOAD.
  - LOAD: load_ready_o=1. Each load_valid_i&&load_ready_o writes buffer[wr_ptr] and increments wr_ptr. When the beat at wr_ptr==DEPTH-1 is accepted: wr_ptr=0, next state STREAM.
  - STREAM:
    - out_valid_o rises the cycle after entry; first data = buffer[0]. Load-to-stream latency is 1 cycle.
    - Transfer on out_valid_o&&out_ready_i; next beat is presented in the following cycle with no bubble while ready is held.
    - out_last_o=1 exactly with beat DEPTH-1.
    - On the last transfer: burst_cnt_o+1. If the new count==BURST_NUM -> DONE, else -> LOAD. out_valid_o drops the next cycle.
  - DONE: done_o=1 and burst_cnt_o=BURST_NUM, held. start_i clears burst_cnt_o and done_o -> LOAD.
- Handshake:
  - While out_valid_o&&!out_ready_i: out_data_o and out_last_o stable, no pointer advance.
  - out_valid_o never drops without a transfer.
- start_i while busy_o=1 is ignored.
- DEPTH=1: every beat is last. LOAD and STREAM each last one transfer.
- load_valid_i outside LOAD is ignored (load_ready_o=0).
- Reset asserted mid-burst: immediate return to IDLE; partial burst discarded; no out_valid_o until a full reload.
- Pointers are $clog2(DEPTH) bits, minimum 1; wrap explicitly at DEPTH-1, not at power of two.

Optional Feature:
- Macro: TLM_BURST_STREAMER_CSUM_EN.
- Defined:
  - Adds output csum_o (ITEM_WIDTH) and csum_valid_o (1).
  - csum_o is the XOR of all CHANNELS*DEPTH items accepted in the current LOAD.
  - It is registered and csum_valid_o pulses for one cycle on the cycle after the final load beat.
  - Both are reset to 0. The accumulator clears on entry to LOAD.
- Not defined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Defaults, loader beats {B=i+1,A=i} for i=0..99, out_ready_i=1 -> 100 beats per burst, out_data_o[7:0]=i, out_last_o only at i=99, 5 bursts, then done_o=1, burst_cnt_o=5.
- out_ready_i toggling 1,0,0,1 pattern -> each beat appears exactly once in order; data stable across stalls; total 100 transfers per burst.
- DEPTH=1, BURST_NUM=3, data 0xA5/0x5A -> three LOAD/STREAM pairs; out_last_o high on every transfer; done after third.
- Reset pulse during beat 40 of burst 2 -> outputs zero asynchronously; state IDLE; burst_cnt_o=0; start_i plus full reload restarts from beat 0.
- start_i pulsed during STREAM -> no effect. start_i in DONE -> burst_cnt_o=0, load_ready_o=1 next cycle.
- CSUM_EN, DEPTH=4, CHANNELS=2, items 0x01..0x08 -> csum_o=0x08, csum_valid_o one-cycle pulse after 4th load beat.
